// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: (r, theta in Q16.16 degrees) -> (r*cos, r*sin), one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain (one extra cycle).
module cordic_rotate #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_r,
  input  logic signed [31:0] in_theta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_x,
  output logic signed [31:0] out_y
);

  localparam int DATA_W = 34;
  localparam int ANG_W  = 33;
  localparam int COEF_W = 17;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic signed [31:0] DEG90  = 32'sd5898240;
  localparam logic signed [31:0] DEG180 = 32'sd11796480;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
`endif

  state_t state, state_nx;
  logic [3:0] idx;

  logic signed [DATA_W-1:0] x_p0, y_p0, x_p1, y_p1, x_sh, y_sh, x_ld;
  logic signed [ANG_W-1:0]  z_p0, z_p1, z_ld, at;
  logic signed [31:0]       theta_c;

  function automatic logic signed [ANG_W-1:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    return 33'sd2949120;
      4'd1:    return 33'sd1740967;
      4'd2:    return 33'sd919879;
      4'd3:    return 33'sd466945;
      4'd4:    return 33'sd234378;
      4'd5:    return 33'sd117303;
      4'd6:    return 33'sd58666;
      4'd7:    return 33'sd29334;
      4'd8:    return 33'sd14668;
      4'd9:    return 33'sd7334;
      4'd10:   return 33'sd3667;
      4'd11:   return 33'sd1833;
      4'd12:   return 33'sd917;
      4'd13:   return 33'sd458;
      4'd14:   return 33'sd229;
      default: return 33'sd115;
    endcase
  endfunction

  function automatic logic signed [31:0] clamp_angle(input logic signed [31:0] a);
    if (a > DEG180)
      return DEG180;
    else if (a < -DEG180)
      return -DEG180;
    else
      return a;
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [COEF_W-1:0] GAIN_K = 17'sd39797;

  // Truncating multiply by 1/K in Q0.16; no rounding term.
  function automatic logic signed [DATA_W-1:0] gain_scale(input logic signed [DATA_W-1:0] v);
    return DATA_W'((51'(v) * 51'(GAIN_K)) >>> 16);
  endfunction

  logic signed [DATA_W-1:0] x_sc, y_sc;
  assign x_sc = gain_scale(x_p0);
  assign y_sc = gain_scale(y_p0);
`endif

  // Load: clamp, then fold |theta| > 90 deg into the convergence range by negating r.
  always_comb begin
    theta_c = clamp_angle(in_theta);
    x_ld    = DATA_W'(in_r);
    z_ld    = ANG_W'(theta_c);
    if (theta_c > DEG90) begin
      x_ld = -DATA_W'(in_r);
      z_ld = ANG_W'(theta_c) - ANG_W'(DEG180);
    end else if (theta_c < -DEG90) begin
      x_ld = -DATA_W'(in_r);
      z_ld = ANG_W'(theta_c) + ANG_W'(DEG180);
    end
  end

  // Micro-rotation step
  always_comb begin
    x_sh = x_p0 >>> idx;
    y_sh = y_p0 >>> idx;
    at   = atan_lut(idx);
    if (!z_p0[ANG_W-1]) begin
      x_p1 = x_p0 - y_sh;
      y_p1 = y_p0 + x_sh;
      z_p1 = z_p0 - at;
    end else begin
      x_p1 = x_p0 + y_sh;
      y_p1 = y_p0 - x_sh;
      z_p1 = z_p0 + at;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        x_p0 <= x_ld;
        y_p0 <= '0;
        z_p0 <= z_ld;
      end
      S_ITER: begin
        x_p0 <= x_p1;
        y_p0 <= y_p1;
        z_p0 <= z_p1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_ITER;
`ifdef CORDIC_GAIN_COMP_EN
      S_ITER:  if (idx == LAST) state_nx = S_SCALE;
      S_SCALE: state_nx = S_DONE;
`else
      S_ITER:  if (idx == LAST) state_nx = S_DONE;
`endif
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && !rst;
    out_valid = (state == S_DONE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)
      idx <= '0;
    else if (state == S_ITER)
      idx <= idx + 4'd1;
    else
      idx <= '0;
  end

  // Result registers hold their value through the output handshake and into IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_x <= '0;
      out_y <= '0;
`ifdef CORDIC_GAIN_COMP_EN
    end else if (state == S_SCALE) begin
      out_x <= x_sc[31:0];
      out_y <= y_sc[31:0];
`else
    end else if (state == S_ITER && idx == LAST) begin
      out_x <= x_p1[31:0];
      out_y <= y_p1[31:0];
`endif
    end
  end

endmodule

// File: doc/cordic_rotate.md
# cordic_rotate

Iterative rotation-mode CORDIC that consumes a signed angle in the same Q16.16-degree format produced by the `arctan` vectoring stage and returns the rotated vector (r·cos θ, r·sin θ). It sits directly downstream of `arctan` in the polar/rectangular datapath. It does one micro-rotation per clock behind valid/ready handshakes on input and output. Reset is synchronous, and one transaction is in flight at a time.

## Interface
- `ITER`, default 16: number of micro-rotations; legal range 1..16.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `in_r`  in  32  signed magnitude; legal range |r| ≤ 2^30−1.
- `in_theta`  in  32  signed angle, Q16.16 degrees; 65536 = 1°.
- `out_valid`  out  1  result present; high only in DONE.
- `out_ready`  in  1  downstream accepts result.
- `out_x`  out  32  signed r·cos θ.
- `out_y`  out  32  signed r·sin θ.

## Operation
- States are IDLE, ITER, SCALE and DONE. SCALE exists only with the macro defined.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1, load the pre-rotated registers, set i=0, and go to ITER.
- **Clamp:** θ above +11796480 (180°) is treated as 180°; θ below −11796480 is treated as −180°.
- **Pre-rotation:**
  - θ > 5898240 (90°): x=−r, y=0, z=θ−11796480.
  - θ < −5898240: x=−r, y=0, z=θ+11796480.
  - Otherwise: x=r, y=0, z=θ.
- **ITER**, one step per cycle, with d = (z ≥ 0):
  - x' = x ∓ (y>>>i)
  - y' = y ± (x>>>i)
  - z' = z ∓ atan[i]
  - Then i=i+1. After step ITER−1, go to SCALE if the macro is defined, otherwise to DONE.
- **Datapath widths:** x and y are 34-bit signed. z is 33-bit signed. Shifts are arithmetic, and there is no rounding.
- **atan table** (Q16.16 degrees, i=0..15): 2949120, 1740967, 919879, 466945, 234378, 117303, 58666, 29334, 14668, 7334, 3667, 1833, 917, 458, 229, 115.
- **DONE**
  - `out_valid`=1.
  - `out_x`/`out_y` are the low 32 bits of the final x/y and hold stable until `out_ready`=1.
  - On that edge, go to IDLE. `out_x`/`out_y` keep their values; only `out_valid` drops.
- There is no input acceptance outside IDLE. A new transaction may be accepted no earlier than the cycle after the output handshake.

## Timing
- **Reset values:** `in_ready`=0 during the reset cycle, then 1 in IDLE. `out_valid`=0, `out_x`=0, `out_y`=0, state=IDLE, i=0.
- **Reset mid-operation:** the in-flight transaction is dropped with no output. The block is in IDLE on the first edge with `rst`=0.
- **Latency:** counted from the accept edge to the first cycle with `out_valid`=1.
  - ITER+1 edges without the macro (17 for the default).
  - ITER+2 edges with the macro (18 for the default).
- **Throughput:** one result per latency+1 cycles when `out_ready` is tied high.
- **Back-pressure:** `out_valid` stays asserted and `out_x`/`out_y` stay constant for any number of cycles while `out_ready`=0.
- **Simultaneous events:** `in_valid` during DONE is ignored, and `in_ready`=0 signals this. `rst` overrides every handshake in the same cycle.

## Configuration
- Macro: `CORDIC_GAIN_COMP_EN`.
- **Defined:** SCALE state computes x,y = (x·39797)>>>16, where 39797 = K≈0.6072529 in Q0.16. It uses a 34×17 signed product, truncated, and costs one extra cycle. Outputs have unit gain.
- **Undefined:** no SCALE state and no multiplier. Outputs carry the CORDIC gain ≈1.6467602 and latency is one cycle shorter.

## Test plan
All checks use ITER=16 and tolerance ±64 LSB.
- **θ = 0:** r=16777216, θ=0, macro defined → `out_x`=16777216, `out_y`=0; `out_valid` rises 18 edges after accept.
- **θ = 90°:** r=16777216, θ=5898240 → `out_x`=0, `out_y`=16777216. Then θ=11796480 (180°) → `out_x`=−16777216, `out_y`=0, which exercises pre-rotation.
- **θ = −135°:** r=16777216, θ=−8847360 → `out_x`=`out_y`=−11863283. θ=20000000 (out of range) → same result as 180°.
- **Gain uncompensated:** macro undefined, r=16777216, θ=0 → `out_x`=27628052, `out_y`=0, latency 17 edges.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles in DONE → `out_valid`=1, outputs unchanged, `in_ready`=0, and a concurrent `in_valid` is not accepted. Then release → IDLE next cycle.
- **Reset mid-operation:** assert `rst` at iteration 7 for 1 cycle → `out_valid` never rises for that job. The next job, r=16777216, θ=0, completes correctly.
